fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage directly downstream of the program counter. Takes the PC value
//   each cycle, issues a 1-cycle-latency synchronous IMEM read, and buffers {pc, inst}
//   pairs in a small FIFO toward decode.
//   Back-pressures the PC through fetch_stall and discards stale/in-flight fetches on a
//   redirect (branch/jump) flush.
// PARAMETERS
//   DEPTH     2              FIFO entries (power of 2, >=2); bounds outstanding+buffered fetches
//   NOP_INST  32'h0000_0013  instruction presented to decode when dec_valid=0 (addi x0,x0,0)
// PORTS
//   clk          in   1   rising-edge clock
//   reset_n      in   1   asynchronous, active-low reset
//   pc           in   32  address to fetch this cycle (from program counter)
//   flush        in   1   redirect: kill in-flight and buffered fetches
//   fetch_stall  out  1   1 = hold pc; stage cannot accept a new fetch this cycle
//   imem_req     out  1   IMEM read enable
//   imem_addr    out  32  IMEM word address ({pc[31:2],2'b00})
//   imem_rdata   in   32  IMEM data, valid the cycle after an accepted imem_req
//   dec_valid    out  1   FIFO head valid toward decode
//   dec_ready    in   1   decode consumes head when dec_valid & dec_ready
//   dec_pc       out  32  PC of head entry (0 when !dec_valid)
//   dec_inst     out  32  instruction of head entry (NOP_INST when !dec_valid)
// BEHAVIOUR
//   - Reset (async assert, sync release): FIFO empty, inflight=0, killed=0, dec_valid=0,
//     dec_pc=0, dec_inst=NOP_INST, imem_req=0 while reset_n=0, fetch_stall=0.
//   - Credit: occ = fifo_count + inflight (0..DEPTH); pop = dec_valid & dec_ready.
//     can_issue = (occ - pop) < DEPTH; imem_req = can_issue & !flush & reset_n.
//     fetch_stall = !can_issue (combinational; also 1 while flush to freeze the redirect target
//     for one cycle is NOT required: PC consumes alu_result on flush, stall ignored by PC then).
//   - Issue cycle N: inflight<=1, inflight_pc<=pc. Cycle N+1: imem_rdata pushed with
//     inflight_pc unless killed. Exactly one outstanding read max; inflight cleared if no new req.
//   - Latency: pc presented in cycle N with empty FIFO -> dec_valid=1 with that pc in N+1
//     (head read combinationally from the push data is NOT allowed; head comes from
//     registered storage, so first valid is N+2). Fixed: 2 cycles pc->dec_valid.
//   - FIFO: circular, ptr width $clog2(DEPTH), count width $clog2(DEPTH)+1; ptrs wrap mod
//     DEPTH. Push and pop in same cycle on full FIFO allowed (count unchanged).
//     Push when full is impossible by credit; assertion required.
//   - Flush (cycle F): FIFO emptied at F+1 (count=0, ptrs reset to 0); any read issued before
//     F has data dropped (killed<=inflight); no imem_req in F. Flush overrides simultaneous
//     push and pop; a pop in cycle F still counts as consumed by decode.
//   - Flush and reset mid-fetch: no stale instruction ever appears on dec_* afterwards.
//   - dec_* outputs are stable while dec_valid & !dec_ready & !flush.
// STRUCTURE
//   - Shared package/header (pipeline defines file): NOP_INST, PC_RESET, inst/addr widths
//     macros.
//   - One sub-module: fetch_fifo (DEPTH x 64-bit {pc,inst} storage, push/pop/clear,
//     count, async active-low reset). Credit/inflight/kill logic stays in fetch_stage.
// TESTING
//   1 Reset: hold reset_n=0 with pc=0x2000 -> imem_req=0, dec_valid=0, dec_inst=0x13,
//     fetch_stall=0.
//   2 Stream: dec_ready=1, pc=0x2000,0x2004,0x2008 consecutive, imem returns mem[addr] ->
//     dec_pc 0x2000.. each cycle from cycle 2, fetch_stall never 1.
//   3 Back-pressure: dec_ready=0 after 1st valid -> fetch_stall=1 once occ=DEPTH, imem_req=0,
//     dec_pc held at 0x2000; dec_ready=1 -> in-order drain, no loss/duplication.
//   4 Flush in flight: issue 0x2004, flush next cycle with FIFO holding 0x2000 -> 0x2000 and
//     0x2004 never (re)appear; next pc 0x3000 -> dec_pc=0x3000 two cycles later.
//   5 Full + simultaneous push/pop with DEPTH=4: pointer wrap over 10 entries -> order preserved.
//   6 Async reset asserted mid-stream (between edges) -> dec_valid drops immediately, no
//     stale entry after release.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-pipeline definitions: widths, reset PC, the NOP bubble and the fetch entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   INST_W / ADDR_W  instruction and address widths
//   NOP_INST         instruction shown to decode when no valid entry is presented
//   PC_RESET         reset value for PC-holding registers
//   fetch_entry_t    {pc, inst} pair buffered between fetch and decode
package fetch_stage_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    // addi x0, x0, 0
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] PC_RESET = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_fifo.sv
// Circular DEPTH-entry buffer of {pc, inst} pairs with push/pop/clear and an occupancy count.
// Latency: a push is visible at the head on the cycle after it is written (registered storage).
// Backpressure: none internally; the owner must never push into a full buffer without a pop.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   clear                empty the buffer (overrides push and pop)
//   push, push_dat       write an entry at the tail
//   pop                  drop the head entry (ignored when empty)
//   head_vld, head_dat   head entry and its valid flag
//   count                number of stored entries (0..DEPTH)
module fetch_fifo
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         push,
    input  fetch_entry_t                 push_dat,
    input  logic                         pop,
    output logic                         head_vld,
    output fetch_entry_t                 head_dat,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            pop_ok;

    assign head_vld = (count != '0);
    assign head_dat = mem[rd_ptr];
    assign pop_ok   = pop & head_vld;

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their natural width.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A push into a full buffer without a matching pop would overwrite the head.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !clear && !pop_ok && (count == CW'(DEPTH))));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: issues a 1-cycle IMEM read per accepted PC and queues {pc, inst} toward decode.
// Latency: PC accepted in cycle N appears on dec_* in cycle N+2.
// Backpressure: credit-based; fetch_stall rises when buffered + in-flight fetches would reach DEPTH.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   pc                 address to fetch this cycle
//   flush              redirect: drop the in-flight read and every buffered entry
//   fetch_stall        1 = the PC must hold; no fetch accepted this cycle
//   imem_req/addr      IMEM read enable and word-aligned address
//   imem_rdata         IMEM data, valid the cycle after imem_req
//   dec_valid/ready    head handshake toward decode
//   dec_pc/dec_inst    head entry (0 / NOP_INST when dec_valid is low)
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = fetch_stage_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        fetch_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_inst
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic              inflight;
    logic              killed;
    logic [31:0]       inflight_pc;

    logic              head_vld;
    fetch_entry_t      head_dat;
    fetch_entry_t      push_dat;
    logic [CW-1:0]     count;
    logic [CW-1:0]     occ;
    logic [CW-1:0]     occ_after_pop;
    logic              pop;
    logic              push;
    logic              can_issue;

    // ------------------------------------------------------------------
    // Credit: every outstanding read already owns a buffer slot, so the
    // occupancy seen by the issue logic is stored entries plus the read in
    // flight. An entry leaving this cycle frees its slot immediately.
    // ------------------------------------------------------------------
    assign pop           = head_vld & dec_ready;
    assign occ           = count + CW'(inflight);
    assign occ_after_pop = occ - CW'(pop);
    assign can_issue     = (occ_after_pop < CW'(DEPTH));

    assign fetch_stall   = ~can_issue;
    assign imem_req      = can_issue & ~flush & reset_n;
    assign imem_addr     = {pc[31:2], 2'b00};

    // A response is buffered unless a redirect has overtaken it; a redirect
    // in the response cycle itself wins over the push.
    assign push          = inflight & ~killed & ~flush;
    assign push_dat      = '{pc: inflight_pc, inst: imem_rdata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight    <= 1'b0;
            killed      <= 1'b0;
            inflight_pc <= PC_RESET;
        end else begin
            inflight <= imem_req;
            // Marks a read that was outstanding when a redirect hit, so its
            // data can never reach the buffer even if it lands late.
            killed   <= flush & inflight;
            if (imem_req) begin
                inflight_pc <= pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (flush),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_vld (head_vld),
        .head_dat (head_dat),
        .count    (count)
    );

    // The head is always taken from registered storage, never bypassed from
    // the IMEM response, which fixes the PC-to-decode latency at two cycles.
    assign dec_valid = head_vld;
    assign dec_pc    = head_vld ? head_dat.pc   : 32'h0;
    assign dec_inst  = head_vld ? head_dat.inst : NOP_INST;

    a_occ_bound: assert property (@(posedge clk) disable iff (!reset_n)
        occ <= CW'(DEPTH));

    a_head_stable: assert property (@(posedge clk) disable iff (!reset_n)
        (dec_valid && !dec_ready && !flush) |=> ($stable(dec_pc) && $stable(dec_inst)));

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc_v    [2];
    logic        flush_v [2];
    logic        rdy_v   [2];
    logic        stall_v [2];
    logic        req_v   [2];
    logic        dv      [2];
    logic [31:0] addr_v  [2];
    logic [31:0] rdata_v [2];
    logic [31:0] dpc_v   [2];
    logic [31:0] dinst_v [2];

    logic [63:0] exp_q  [2][$];
    logic [63:0] got_q  [2][$];
    logic [63:0] want_q [2][$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_stage #(.DEPTH(2)) u_d2 (
        .clk(clk), .reset_n(reset_n), .pc(pc_v[0]), .flush(flush_v[0]),
        .fetch_stall(stall_v[0]), .imem_req(req_v[0]), .imem_addr(addr_v[0]),
        .imem_rdata(rdata_v[0]), .dec_valid(dv[0]), .dec_ready(rdy_v[0]),
        .dec_pc(dpc_v[0]), .dec_inst(dinst_v[0])
    );

    fetch_stage #(.DEPTH(4)) u_d4 (
        .clk(clk), .reset_n(reset_n), .pc(pc_v[1]), .flush(flush_v[1]),
        .fetch_stall(stall_v[1]), .imem_req(req_v[1]), .imem_addr(addr_v[1]),
        .imem_rdata(rdata_v[1]), .dec_valid(dv[1]), .dec_ready(rdy_v[1]),
        .dec_pc(dpc_v[1]), .dec_inst(dinst_v[1])
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // IMEM model: one-cycle synchronous read; garbage when not requested.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            rdata_v[i] <= req_v[i] ? mem_word(addr_v[i]) : 32'hBAD0_0BAD;
        end
    end

    // One clock of the bench PC/decode model. Records every decode handshake
    // against the oldest outstanding expectation, registers newly accepted
    // fetches, and advances each PC the way a program counter would.
    task automatic cycle();
        bit acc [2];
        acc[0] = 1'b0;
        acc[1] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (reset_n === 1'b1) begin
                if (dv[i] === 1'b1 && rdy_v[i] === 1'b1) begin
                    got_q[i].push_back({dpc_v[i], dinst_v[i]});
                    if (exp_q[i].size() > 0) want_q[i].push_back(exp_q[i].pop_front());
                    else                     want_q[i].push_back(64'hDEAD_DEAD_DEAD_DEAD);
                end
                if (flush_v[i]) begin
                    exp_q[i].delete();
                end else if (stall_v[i] === 1'b0) begin
                    exp_q[i].push_back({pc_v[i], mem_word({pc_v[i][31:2], 2'b00})});
                    acc[i] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) if (acc[i]) pc_v[i] = pc_v[i] + 32'd4;
    endtask

    task automatic go_idle();
        flush_v[0] = 1'b1;
        flush_v[1] = 1'b1;
        cycle();
        cycle();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pc_v[i] = 32'h2000; flush_v[i] = 1'b0; rdy_v[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (req_v[0] !== 1'b0)    begin n_bad++; $display("FAIL reset_imem_req: got %b want 0", req_v[0]); end
        n_cmp++; if (dv[0] !== 1'b0)       begin n_bad++; $display("FAIL reset_dec_valid: got %b want 0", dv[0]); end
        n_cmp++; if (dinst_v[0] !== 32'h13) begin n_bad++; $display("FAIL reset_dec_inst: got %h want 00000013", dinst_v[0]); end
        n_cmp++; if (dpc_v[0] !== 32'h0)   begin n_bad++; $display("FAIL reset_dec_pc: got %h want 0", dpc_v[0]); end
        n_cmp++; if (stall_v[0] !== 1'b0)  begin n_bad++; $display("FAIL reset_fetch_stall: got %b want 0", stall_v[0]); end
        n_cmp++; if (req_v[1] !== 1'b0 || dv[1] !== 1'b0)
                     begin n_bad++; $display("FAIL reset_d4: got req=%b valid=%b want 0/0", req_v[1], dv[1]); end
        flush_v[0] = 1'b1;
        flush_v[1] = 1'b1;
        reset_n    = 1'b1;
        cycle();
        cycle();
    endtask

    task automatic test_stream();
        logic [63:0] g, w;
        pc_v[0] = 32'h2000; flush_v[0] = 1'b0; rdy_v[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_cmp++; if (stall_v[0] !== 1'b0) begin n_bad++; $display("FAIL stream_stall k=%0d: got %b want 0", k, stall_v[0]); end
            if (k == 1) begin
                n_cmp++; if (dv[0] !== 1'b0) begin n_bad++; $display("FAIL stream_early_valid: got %b want 0", dv[0]); end
            end
            if (k >= 2) begin
                n_cmp++;
                if (dv[0] !== 1'b1 || dpc_v[0] !== 32'h2000 + 32'(4 * (k - 2)))
                    begin n_bad++; $display("FAIL stream_head k=%0d: got valid=%b pc=%h want 1/%h", k, dv[0], dpc_v[0], 32'h2000 + 32'(4 * (k - 2))); end
            end
            cycle();
        end
        go_idle();
        n_cmp++; if (got_q[0].size() != 7) begin n_bad++; $display("FAIL stream_pops: got %0d want 7", got_q[0].size()); end
        while (got_q[0].size() > 0) begin
            g = got_q[0].pop_front(); w = want_q[0].pop_front();
            n_cmp++;
            if (g !== w) begin n_bad++; $display("FAIL stream_order: got pc=%h inst=%h want pc=%h inst=%h", g[63:32], g[31:0], w[63:32], w[31:0]); end
        end
    endtask

    task automatic test_back_pressure();
        logic [63:0] g, w;
        pc_v[0] = 32'h2000; flush_v[0] = 1'b0; rdy_v[0] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (k >= 2) begin
                n_cmp++; if (stall_v[0] !== 1'b1) begin n_bad++; $display("FAIL bp_stall k=%0d: got %b want 1", k, stall_v[0]); end
                n_cmp++; if (req_v[0] !== 1'b0)   begin n_bad++; $display("FAIL bp_req k=%0d: got %b want 0", k, req_v[0]); end
                n_cmp++;
                if (dv[0] !== 1'b1 || dpc_v[0] !== 32'h2000)
                    begin n_bad++; $display("FAIL bp_hold k=%0d: got valid=%b pc=%h want 1/00002000", k, dv[0], dpc_v[0]); end
            end
            if (k == 5) begin
                n_cmp++; if (dinst_v[0] !== mem_word(32'h2000)) begin n_bad++; $display("FAIL bp_inst: got %h want %h", dinst_v[0], mem_word(32'h2000)); end
            end
            cycle();
        end
        rdy_v[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_cmp++; if (stall_v[0] !== 1'b0) begin n_bad++; $display("FAIL bp_drain_stall k=%0d: got %b want 0", k, stall_v[0]); end
            cycle();
        end
        go_idle();
        n_cmp++; if (got_q[0].size() != 7) begin n_bad++; $display("FAIL bp_pops: got %0d want 7", got_q[0].size()); end
        while (got_q[0].size() > 0) begin
            g = got_q[0].pop_front(); w = want_q[0].pop_front();
            n_cmp++;
            if (g !== w) begin n_bad++; $display("FAIL bp_order: got pc=%h inst=%h want pc=%h inst=%h", g[63:32], g[31:0], w[63:32], w[31:0]); end
        end
    endtask

    task automatic test_flush();
        logic [63:0] g, w;
        pc_v[0] = 32'h2000; flush_v[0] = 1'b0; rdy_v[0] = 1'b0;
        cycle();
        cycle();
        #1;
        n_cmp++;
        if (dv[0] !== 1'b1 || dpc_v[0] !== 32'h2000)
            begin n_bad++; $display("FAIL flush_pre_head: got valid=%b pc=%h want 1/00002000", dv[0], dpc_v[0]); end
        flush_v[0] = 1'b1;
        #1;
        n_cmp++; if (req_v[0] !== 1'b0) begin n_bad++; $display("FAIL flush_req: got %b want 0", req_v[0]); end
        cycle();
        flush_v[0] = 1'b0; pc_v[0] = 32'h3000; rdy_v[0] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_cmp++; if (dv[0] !== 1'b0) begin n_bad++; $display("FAIL flush_stale k=%0d: got valid=%b pc=%h want 0", k, dv[0], dpc_v[0]); end
            cycle();
        end
        #1;
        n_cmp++;
        if (dv[0] !== 1'b1 || dpc_v[0] !== 32'h3000 || dinst_v[0] !== mem_word(32'h3000))
            begin n_bad++; $display("FAIL flush_target: got valid=%b pc=%h inst=%h want 1/00003000/%h", dv[0], dpc_v[0], dinst_v[0], mem_word(32'h3000)); end
        cycle();
        cycle();
        cycle();
        go_idle();
        n_cmp++; if (got_q[0].size() != 4) begin n_bad++; $display("FAIL flush_pops: got %0d want 4", got_q[0].size()); end
        while (got_q[0].size() > 0) begin
            g = got_q[0].pop_front(); w = want_q[0].pop_front();
            n_cmp++;
            if (g !== w) begin n_bad++; $display("FAIL flush_order: got pc=%h inst=%h want pc=%h inst=%h", g[63:32], g[31:0], w[63:32], w[31:0]); end
        end
    endtask

    task automatic test_wrap();
        logic [63:0] g, w;
        pc_v[1] = 32'h4000; flush_v[1] = 1'b0; rdy_v[1] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (k >= 4) begin
                n_cmp++; if (stall_v[1] !== 1'b1) begin n_bad++; $display("FAIL wrap_full_stall k=%0d: got %b want 1", k, stall_v[1]); end
            end
            if (k == 5) begin
                n_cmp++;
                if (dv[1] !== 1'b1 || dpc_v[1] !== 32'h4000)
                    begin n_bad++; $display("FAIL wrap_head: got valid=%b pc=%h want 1/00004000", dv[1], dpc_v[1]); end
            end
            cycle();
        end
        for (int k = 0; k < 30; k++) begin
            rdy_v[1] = (k < 10) ? 1'b1 : 1'($urandom_range(0, 1));
            cycle();
        end
        go_idle();
        rdy_v[1] = 1'b0;
        n_cmp++; if (got_q[1].size() < 10) begin n_bad++; $display("FAIL wrap_pops: got %0d want >=10", got_q[1].size()); end
        while (got_q[1].size() > 0) begin
            g = got_q[1].pop_front(); w = want_q[1].pop_front();
            n_cmp++;
            if (g !== w) begin n_bad++; $display("FAIL wrap_order: got pc=%h inst=%h want pc=%h inst=%h", g[63:32], g[31:0], w[63:32], w[31:0]); end
        end
    endtask

    task automatic test_async_reset();
        logic [63:0] g, w;
        pc_v[0] = 32'h2000; flush_v[0] = 1'b0; rdy_v[0] = 1'b0;
        repeat (3) cycle();
        #2;
        reset_n = 1'b0;
        exp_q[0].delete();
        exp_q[1].delete();
        #1;
        n_cmp++; if (dv[0] !== 1'b0)        begin n_bad++; $display("FAIL areset_valid: got %b want 0", dv[0]); end
        n_cmp++; if (dinst_v[0] !== 32'h13) begin n_bad++; $display("FAIL areset_inst: got %h want 00000013", dinst_v[0]); end
        n_cmp++; if (req_v[0] !== 1'b0 || stall_v[0] !== 1'b0)
                     begin n_bad++; $display("FAIL areset_req_stall: got req=%b stall=%b want 0/0", req_v[0], stall_v[0]); end
        cycle();
        cycle();
        pc_v[0] = 32'h5000; rdy_v[0] = 1'b1;
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (k < 2) begin
                n_cmp++; if (dv[0] !== 1'b0) begin n_bad++; $display("FAIL areset_stale k=%0d: got valid=%b pc=%h want 0", k, dv[0], dpc_v[0]); end
            end else begin
                n_cmp++;
                if (dv[0] !== 1'b1 || dpc_v[0] !== 32'h5000 + 32'(4 * (k - 2)))
                    begin n_bad++; $display("FAIL areset_head k=%0d: got valid=%b pc=%h want 1/%h", k, dv[0], dpc_v[0], 32'h5000 + 32'(4 * (k - 2))); end
            end
            cycle();
        end
        go_idle();
        n_cmp++; if (got_q[0].size() != 4) begin n_bad++; $display("FAIL areset_pops: got %0d want 4", got_q[0].size()); end
        while (got_q[0].size() > 0) begin
            g = got_q[0].pop_front(); w = want_q[0].pop_front();
            n_cmp++;
            if (g !== w) begin n_bad++; $display("FAIL areset_order: got pc=%h inst=%h want pc=%h inst=%h", g[63:32], g[31:0], w[63:32], w[31:0]); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
